// File: rtl/muladd_pkg.sv
// Shared types and helpers for the sequential multiply-add unit.
package muladd_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Width of the iteration counter for an n-bit operand.
  function automatic int CNT_W(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/muladd_step.sv
// One shift-and-add iteration: conditionally add the multiplicand, then
// advance the multiplicand left and the multiplier right by one bit.
module muladd_step #(
  parameter int N = 8
) (
  input  logic [2*N-1:0] acc,
  input  logic [2*N-1:0] mcand,
  input  logic [N-1:0]   mplr,
  output logic [2*N-1:0] acc_next,
  output logic [2*N-1:0] mcand_next,
  output logic [N-1:0]   mplr_next
);

  // The accumulator cannot wrap: the largest reachable sum is 2^2N - 2^N.
  always_comb begin
    acc_next   = mplr[0] ? (acc + mcand) : acc;
    mcand_next = mcand << 1;
    mplr_next  = mplr >> 1;
  end

endmodule

// File: rtl/seq_mul_add.sv
// Iterative multiply-accumulate: result = q_in * b_in + r_in, one bit per cycle.
// Optional overflow flag enabled by defining SEQ_MUL_ADD_OVF_EN.
//
//   state | meaning
//   IDLE  | ready high, waiting for start
//   RUN   | N shift-and-add iterations, cnt counts 0..N-1
//   DONE  | done pulse, result just updated; returns to IDLE
module seq_mul_add
  import muladd_pkg::*;
#(
  parameter int N = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [N-1:0]   q_in,
  input  logic [N-1:0]   b_in,
  input  logic [N-1:0]   r_in,
  output logic           ready,
  output logic           done,
  output logic [2*N-1:0] result
`ifdef SEQ_MUL_ADD_OVF_EN
  ,
  output logic           ovf
`endif
);

  localparam int CW = CNT_W(N);

  state_t         state, state_next;
  logic [2*N-1:0] acc, mcand;
  logic [N-1:0]   mplr;
  logic [CW-1:0]  cnt;
  logic [2*N-1:0] acc_step, mcand_step;
  logic [N-1:0]   mplr_step;
  logic           accept, last_iter;

  muladd_step #(.N(N)) u_step (
    .acc        (acc),
    .mcand      (mcand),
    .mplr       (mplr),
    .acc_next   (acc_step),
    .mcand_next (mcand_step),
    .mplr_next  (mplr_step)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic and handshake outputs.
  always_comb begin
    state_next = state;
    ready      = 1'b0;
    done       = 1'b0;
    accept     = 1'b0;
    last_iter  = 1'b0;
    unique case (state)
      IDLE: begin
        ready  = 1'b1;
        accept = start;
        if (start) state_next = RUN;
      end
      RUN: begin
        last_iter = (cnt == CW'(N - 1));
        if (last_iter) state_next = DONE;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Operand latch on acceptance, then one iteration per RUN cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc   <= '0;
      mcand <= '0;
      mplr  <= '0;
      cnt   <= '0;
    end else if (accept) begin
      acc   <= {{N{1'b0}}, r_in};
      mcand <= {{N{1'b0}}, b_in};
      mplr  <= q_in;
      cnt   <= '0;
    end else if (state == RUN) begin
      acc   <= acc_step;
      mcand <= mcand_step;
      mplr  <= mplr_step;
      cnt   <= cnt + CW'(1);
    end
  end

  // Result register loads only on the edge that enters DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         result <= '0;
    else if (last_iter) result <= acc_step;
  end

`ifdef SEQ_MUL_ADD_OVF_EN
  // Overflow: the result does not fit back into N bits; held with result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         ovf <= 1'b0;
    else if (last_iter) ovf <= |acc_step[2*N-1:N];
  end
`endif

endmodule

// File: tb/tb_seq_mul_add.sv
// Self-checking bench for seq_mul_add (N = 8). Reference model is plain
// arithmetic q*b+r with a fixed N-cycle latency after the accepting edge.
// Define SEQ_MUL_ADD_OVF_EN to also check the overflow flag.
module tb_seq_mul_add;

  localparam int N = 8;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           start = 1'b0;
  logic [N-1:0]   q_in = '0, b_in = '0, r_in = '0;
  logic           ready, done;
  logic [2*N-1:0] result;
`ifdef SEQ_MUL_ADD_OVF_EN
  logic           ovf;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  seq_mul_add #(.N(N)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .q_in   (q_in),
    .b_in   (b_in),
    .r_in   (r_in),
    .ready  (ready),
    .done   (done),
    .result (result)
`ifdef SEQ_MUL_ADD_OVF_EN
    ,
    .ovf    (ovf)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic [2*N-1:0] model(input logic [N-1:0] q, b, r);
    return (2*N)'(int'(q) * int'(b) + int'(r));
  endfunction

  // Issue one operation and check the whole handshake timeline.
  task automatic run_op(input logic [N-1:0] q, b, r);
    logic [2*N-1:0] exp, prev;
    exp  = model(q, b, r);
    prev = result;
    @(negedge clk);
    start = 1'b1; q_in = q; b_in = b; r_in = r;
    @(posedge clk); #1;
    check("ready_low_after_accept", 32'(ready), 32'd0);
    start = 1'b0;
    q_in = N'($urandom); b_in = N'($urandom); r_in = N'($urandom);
    for (int k = 1; k <= N; k++) begin
      @(posedge clk); #1;
      if (k == 1) check("result_held_in_run", 32'(result), 32'(prev));
      if (k == N - 1) check("no_early_done", 32'(done), 32'd0);
      if (k == N) begin
        check("done_at_latency", 32'(done), 32'd1);
        check("result", 32'(result), 32'(exp));
`ifdef SEQ_MUL_ADD_OVF_EN
        check("ovf", 32'(ovf), 32'(exp[2*N-1:N] != '0));
`endif
      end
    end
    @(posedge clk); #1;
    check("done_one_cycle", 32'(done), 32'd0);
    check("ready_back", 32'(ready), 32'd1);
    check("result_holds", 32'(result), 32'(exp));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int dones;
    int t_prev, t_cur;
    #12;
    check("reset_ready", 32'(ready), 32'd1);
    check("reset_done", 32'(done), 32'd0);
    check("reset_result", 32'(result), 32'd0);
`ifdef SEQ_MUL_ADD_OVF_EN
    check("reset_ovf", 32'(ovf), 32'd0);
`endif
    @(negedge clk); rst_n = 1'b1;

    // Directed cases.
    run_op(8'd13, 8'd7, 8'd5);
    run_op(8'd255, 8'd255, 8'd255);
    run_op(8'd0, 8'd200, 8'd0);

    // Operand changes and a second start during RUN are ignored.
    @(negedge clk);
    start = 1'b1; q_in = 8'd3; b_in = 8'd4; r_in = 8'd1;
    @(posedge clk); #1;
    start = 1'b0;
    dones = 0;
    for (int k = 1; k <= N + 4; k++) begin
      @(posedge clk); #1;
      if (k == 2) begin q_in = 8'd9; b_in = 8'd9; r_in = 8'd9; start = 1'b1; end
      if (k == 3) start = 1'b0;
      if (done) dones++;
    end
    check("single_done_on_restart", 32'(dones), 32'd1);
    check("result_ignores_late_ops", 32'(result), 32'd13);
    check("second_start_ignored", 32'(ready), 32'd1);

    // Asynchronous reset mid-RUN.
    @(negedge clk);
    start = 1'b1; q_in = 8'd10; b_in = 8'd10; r_in = 8'd10;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("rst_mid_run_ready", 32'(ready), 32'd1);
    check("rst_mid_run_done", 32'(done), 32'd0);
    check("rst_mid_run_result", 32'(result), 32'd0);
    @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    dones = 0;
    for (int k = 0; k < N + 4; k++) begin
      @(posedge clk); #1;
      if (done) dones++;
    end
    check("no_done_after_abort", 32'(dones), 32'd0);
    run_op(8'd6, 8'd7, 8'd8);

    // Start held high: one acceptance per IDLE visit, period N+2.
    @(negedge clk);
    start = 1'b1; q_in = 8'd2; b_in = 8'd3; r_in = 8'd0;
    t_prev = -1;
    dones = 0;
    for (int c = 0; c < 5 * (N + 2) && dones < 4; c++) begin
      @(posedge clk); #1;
      if (done) begin
        check("held_start_result", 32'(result), 32'd6);
        if (t_prev >= 0) check("held_start_interval", 32'(c - t_prev), 32'(N + 2));
        t_prev = c;
        dones++;
      end
    end
    check("held_start_done_count", 32'(dones), 32'd4);
    @(negedge clk); start = 1'b0;
    repeat (N + 3) @(posedge clk);

    // Randomized operations against the arithmetic model.
    for (int i = 0; i < 25; i++)
      run_op(N'($urandom), N'($urandom), N'($urandom));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/seq_mul_add.md
# seq_mul_add

Iterative N-bit multiply-accumulate unit computing result = q_in × b_in + r_in, the inverse of the ALU divider's quotient/remainder operation. It rebuilds a dividend from a divider's Q, B and R outputs and also serves as the ALU's general multiplier, with r_in tied to zero. It uses one shift-and-add iteration per clock and a start/ready/done handshake, so the ALU datapath can issue and collect operations without stalling on a combinational multiplier.

## Interface
- N, 8: operand width in bits; N ≥ 2.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request; sampled only while ready = 1.
- q_in  in  N  multiplier (divider quotient); unsigned.
- b_in  in  N  multiplicand (divisor); unsigned.
- r_in  in  N  addend (remainder); unsigned.
- ready  out  1  high only in IDLE; a new start is accepted.
- done  out  1  one-cycle pulse marking result valid.
- result  out  2N  product plus addend; held until the next accepted start.
- ovf  out  1  present only with SEQ_MUL_ADD_OVF_EN; see Configuration.

## Operation
- FSM states are IDLE, RUN and DONE.
- IDLE:
  - ready = 1.
  - On start = 1: latch mcand = {N'0, b_in}, mplr = q_in, acc = {N'0, r_in}, cnt = 0; go to RUN.
- RUN, one iteration per cycle:
  - if mplr[0], acc ← acc + mcand;
  - mcand ← mcand << 1; mplr ← mplr >> 1; cnt ← cnt + 1.
  - After the iteration with cnt = N−1, go to DONE.
- DONE:
  - done = 1 for exactly this cycle; result = acc.
  - Next state is always IDLE.
- Arithmetic is unsigned and 2N bits wide. The maximum value (2^N−1)² + (2^N−1) = 2^2N − 2^N fits, so there is no wrap.
- start is ignored in RUN and DONE; no queuing, no error flag.
- Operands are latched at acceptance. Changes on q_in, b_in or r_in after acceptance have no effect.
- There is no early termination: latency is fixed regardless of operand values, including zero.
- result is a register that updates only on entry to DONE. It keeps the previous value through IDLE and RUN.

## Timing
- Reset (asynchronous, any state, including mid-RUN): state = IDLE, ready = 1, done = 0, result = 0, ovf = 0, internal registers cleared. The aborted operation produces no done.
- Start accepted at clock edge E0. RUN iterations occur on edges E1..EN. DONE is entered at edge EN, so done is high for the cycle after EN.
- Latency from accepting edge to done is N cycles; initiation interval is N + 2 cycles.
- ready falls at E0, stays low during RUN and DONE, and rises again at the edge leaving DONE.
- A start held high continuously is accepted once per IDLE visit.

## Configuration
- SEQ_MUL_ADD_OVF_EN defined:
  - ovf port and register exist.
  - On entry to DONE: ovf = |acc[2N−1:N], i.e. the result does not fit back into N bits (an invalid reconstructed dividend).
  - ovf holds with result; reset value 0.
- Undefined: no ovf port and no related logic. result behaviour is identical.

## Structure
- Shared package muladd_pkg holds:
  - enum state_t {IDLE, RUN, DONE};
  - localparam function CNT_W(N) = $clog2(N).
- Sub-module muladd_step (combinational): one shift-and-add iteration, taking acc, mcand and mplr and returning their next values.
- seq_mul_add holds the FSM, counter and registers.

## Test plan
All scenarios use N = 8.
- q_in = 13, b_in = 7, r_in = 5, start at E0 → ready low at E0; done high only in the cycle after E8; result = 0x0060; ovf = 0.
- q_in = 255, b_in = 255, r_in = 255 → result = 0xFF00, ovf = 1 (when SEQ_MUL_ADD_OVF_EN is defined); no wrap.
- q_in = 0, b_in = 200, r_in = 0 → done still arrives at the same latency; result = 0x0000.
- Start accepted with q_in = 3, b_in = 4, r_in = 1; operands changed to 9/9/9 and start re-pulsed during RUN → single done, result = 13; second start not accepted.
- rst_n low for one cycle mid-RUN (after E4) → immediately ready = 1, done = 0, result = 0; no done pulse follows; the next start completes normally.
- start held high constantly with q_in = 2, b_in = 3, r_in = 0 → done pulses every 10 cycles, result = 6 each time.
